// File: rtl/norm_arbiter.sv
// Round-robin arbiter over N_REQ FP lanes feeding a single normaliser stage.
// One transaction in flight: IDLE grants, CALC normalises, DONE holds until taken.
module norm_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*25-1:0] req_sig,
  input  logic [N_REQ*8-1:0]  req_exp,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24:0]         out_sig,
  output logic [7:0]          out_exp,
  output logic [ID_W-1:0]     out_id,
  output logic                out_uflow,
  output logic                busy
);

  localparam int unsigned NQ = N_REQ;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [24:0]     lat_sig_q, lat_sig_d;
  logic [7:0]      lat_exp_q, lat_exp_d;
  logic [ID_W-1:0] lat_id_q, lat_id_d;
  logic [24:0]     out_sig_q, out_sig_d;
  logic [7:0]      out_exp_q, out_exp_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            out_uflow_q, out_uflow_d;
  logic            out_valid_q, out_valid_d;

  logic [2*N_REQ-1:0] rot;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [24:0]        sel_sig;
  logic [7:0]         sel_exp;
  logic [4:0]         shift;

  // Rotating the doubled request vector by ptr makes the lowest set bit the next lane upward.
  always_comb begin
    rot       = {req_valid, req_valid} >> ptr_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int unsigned j = 0; j < NQ; j++) begin
      if (!grant_vld && rot[j]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((32'(ptr_q) + j) % NQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_sig   = '0;
    sel_exp   = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_sig      = req_sig[i*25 +: 25];
        sel_exp      = req_exp[i*8 +: 8];
        req_ready[i] = grant_vld && (state_q == IDLE) && !rst;
      end
    end
  end

  // Leading-zero count of sig[23:0]; the highest set bit wins, 24 when none set.
  always_comb begin
    shift = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (lat_sig_q[i]) shift = 5'(23 - i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_sig_d   = lat_sig_q;
    lat_exp_d   = lat_exp_q;
    lat_id_d    = lat_id_q;
    out_sig_d   = out_sig_q;
    out_exp_d   = out_exp_q;
    out_id_d    = out_id_q;
    out_uflow_d = out_uflow_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          lat_sig_d = sel_sig;
          lat_exp_d = sel_exp;
          lat_id_d  = grant_id;
          ptr_d     = ID_W'((32'(grant_id) + 1) % NQ);
          state_d   = CALC;
        end
      end
      CALC: begin
        if (lat_sig_q[24]) begin
          out_sig_d   = lat_sig_q << shift;
          out_exp_d   = lat_exp_q - {3'b000, shift};
          out_uflow_d = lat_exp_q < {3'b000, shift};
        end else begin
          out_sig_d   = ~lat_sig_q + 25'd1;
          out_exp_d   = lat_exp_q;
          out_uflow_d = 1'b0;
        end
        out_id_d    = lat_id_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lat_sig_q   <= '0;
      lat_exp_q   <= '0;
      lat_id_q    <= '0;
      out_sig_q   <= '0;
      out_exp_q   <= '0;
      out_id_q    <= '0;
      out_uflow_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lat_sig_q   <= lat_sig_d;
      lat_exp_q   <= lat_exp_d;
      lat_id_q    <= lat_id_d;
      out_sig_q   <= out_sig_d;
      out_exp_q   <= out_exp_d;
      out_id_q    <= out_id_d;
      out_uflow_q <= out_uflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sig   = out_sig_q;
  assign out_exp   = out_exp_q;
  assign out_id    = out_id_q;
  assign out_uflow = out_uflow_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_norm_arbiter.sv
// Bench for norm_arbiter: directed vectors plus randomized transactions
// compared against an arithmetic normaliser and round-robin reference.
module tb_norm_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*25-1:0] req_sig;
  logic [N*8-1:0] req_exp;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready;
  logic [24:0]    out_sig;
  logic [7:0]     out_exp;
  logic [1:0]     out_id;
  logic           out_uflow;
  logic           busy;

  logic [24:0] lane_sig [N];
  logic [7:0]  lane_exp [N];
  int          ptr_m;
  int          checks = 0;
  int          errors = 0;

  norm_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sig(req_sig),
    .req_exp(req_exp), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
    .out_id(out_id), .out_uflow(out_uflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference normaliser: shift derived from the bit length of the low 24 bits.
  task automatic ref_norm(input logic [24:0] s, input logic [7:0] e,
                          output logic [24:0] os, output logic [7:0] oe, output logic uf);
    longint unsigned v;
    int unsigned low, sh;
    if (s[24]) begin
      low = 32'(s[23:0]);
      sh  = 24 - $clog2(low + 1);
      v   = 64'(s) * (64'd1 << sh);
      os  = v[24:0];
      v   = (64'(e) + 256 - 64'(sh)) % 256;
      oe  = v[7:0];
      uf  = (32'(e) < sh);
    end else begin
      v  = (64'h2000000 - 64'(s)) % 64'h2000000;
      os = v[24:0];
      oe = e;
      uf = 1'b0;
    end
  endtask

  function automatic int ref_grant(input int ptr, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_sig[i*25 +: 25] = lane_sig[i];
      req_exp[i*8 +: 8]   = lane_exp[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rdy", 32'(req_ready), 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_sig", 32'(out_sig), 0);
    check("rst_exp", 32'(out_exp), 0);
    check("rst_id", 32'(out_id), 0);
    check("rst_uf", 32'(out_uflow), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    ptr_m = 0;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) begin
      #1;
      check("idle_rdy", 32'(req_ready), 0);
      check("idle_busy", 32'(busy), 0);
      tick();
    end
  endtask

  // One full transaction from IDLE: grant, CALC, `stall` DONE cycles with out_ready low, accept.
  task automatic run_txn(input logic [N-1:0] mask, input int stall);
    int g;
    logic [24:0] es;
    logic [7:0]  ee;
    logic        eu;
    req_valid = mask;
    pack();
    out_ready = (stall == 0);
    #1;
    g = ref_grant(ptr_m, mask);
    check("grant", 32'(req_ready), 32'(1) << g);
    check("idle_ov", 32'(out_valid), 0);
    check("idle_busy", 32'(busy), 0);
    ref_norm(lane_sig[g], lane_exp[g], es, ee, eu);
    ptr_m = (g + 1) % N;
    tick();
    req_valid = N'($urandom);
    #1;
    check("calc_rdy", 32'(req_ready), 0);
    check("calc_ov", 32'(out_valid), 0);
    check("calc_busy", 32'(busy), 1);
    tick();
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) out_ready = 1'b1;
      req_valid = N'($urandom);
      #1;
      check("done_ov", 32'(out_valid), 1);
      check("done_sig", 32'(out_sig), 32'(es));
      check("done_exp", 32'(out_exp), 32'(ee));
      check("done_id", 32'(out_id), 32'(g));
      check("done_uf", 32'(out_uflow), 32'(eu));
      check("done_rdy", 32'(req_ready), 0);
      tick();
    end
    req_valid = '0;
    out_ready = 1'b0;
    #1;
    check("post_ov", 32'(out_valid), 0);
    check("hold_sig", 32'(out_sig), 32'(es));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_sig = '0;
    req_exp = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_sig[i] = '0;
      lane_exp[i] = '0;
    end
    #2;
    do_reset();

    lane_sig[0] = 25'h1400000; lane_exp[0] = 8'h7F;
    run_txn(4'b0001, 0);
    check("v35_sig", 32'(out_sig), 32'h0800000);
    check("v35_exp", 32'(out_exp), 32'h7E);
    check("v35_id", 32'(out_id), 0);
    check("v35_uf", 32'(out_uflow), 0);

    lane_sig[2] = 25'h1000001; lane_exp[2] = 8'h10;
    run_txn(4'b0100, 0);
    check("v36_sig", 32'(out_sig), 32'h0800000);
    check("v36_exp", 32'(out_exp), 32'hF9);
    check("v36_id", 32'(out_id), 2);
    check("v36_uf", 32'(out_uflow), 1);

    lane_sig[1] = 25'h0000010; lane_exp[1] = 8'h55;
    run_txn(4'b0010, 0);
    check("v37a_sig", 32'(out_sig), 32'h1FFFFF0);
    check("v37a_exp", 32'(out_exp), 32'h55);
    check("v37a_uf", 32'(out_uflow), 0);
    lane_sig[1] = 25'h1000000; lane_exp[1] = 8'h80;
    run_txn(4'b0010, 0);
    check("v37b_sig", 32'(out_sig), 0);
    check("v37b_exp", 32'(out_exp), 32'h68);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      check("rr_ptr", 32'(ptr_m), 32'(k % N));
      run_txn(4'b1111, 0);
    end

    run_txn(4'b1011, 5);

    lane_sig[3] = 25'h1234567; lane_exp[3] = 8'h40;
    pack();
    req_valid = 4'b1000;
    #1;
    check("v40_grant", 32'(req_ready), 32'h8);
    tick();
    rst = 1'b1;
    #1;
    check("v40_ov", 32'(out_valid), 0);
    check("v40_busy", 32'(busy), 0);
    check("v40_rdy", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      req_valid = '0;
      #1;
      check("v40_noout", 32'(out_valid), 0);
      tick();
    end
    run_txn(4'b1111, 0);
    check("v40_id", 32'(out_id), 0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: lane_sig[i] = 25'($urandom);
          1: lane_sig[i] = {1'b1, 24'(32'd1 << $urandom_range(0, 23))};
          2: lane_sig[i] = 25'h1000000;
          default: lane_sig[i] = {1'b0, 24'($urandom)};
        endcase
        lane_exp[i] = 8'($urandom);
      end
      run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3));
      idle_cycles($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
